// File: rtl/paddle_adc_arbiter_if.sv
// ADC handshake bundle between the paddle arbiter (master) and the shared 8-bit ADC (slave).
// adc_req is a level held until the edge that samples adc_done; adc_ch is stable while adc_req
// is high; adc_done is a one-cycle pulse and adc_data is meaningful only in that cycle.
interface paddle_adc_arbiter_if;
    logic       adc_req;
    logic       adc_ch;
    logic       adc_done;
    logic [7:0] adc_data;

    modport master (output adc_req, output adc_ch, input adc_done, input adc_data);
    modport slave  (input adc_req, input adc_ch, output adc_done, output adc_data);
endinterface

// File: rtl/paddle_adc_arbiter.sv
// Time-shares one ADC between the two paddle pots: on each sample tick it converts ch0 then ch1,
// scales each sample to the playfield y range and holds the results as registered positions.
module paddle_adc_arbiter #(
    parameter int SAMPLE_DIV = 50000,
    parameter int TIMEOUT    = 1024,
    parameter int Y_MIN      = 30,
    parameter int Y_SPAN     = 420
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    input  logic                        clr_err_i,
    paddle_adc_arbiter_if.master        adc,
    output logic [10:0]                 p1_y_o,
    output logic [10:0]                 p2_y_o,
    output logic                        round_stb_o,
    output logic                        timeout_err_o,
    output logic [2:0]                  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV0 = 3'd1,
        S_GAP   = 3'd2,
        S_CONV1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int              DW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [10:0]     POS_RST   = 11'd240;
    localparam logic [10:0]     Y_MIN_W   = 11'(Y_MIN);
    localparam logic [18:0]     SPAN_W    = 19'(Y_SPAN);

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            adc_req_q, adc_req_d;
    logic            adc_ch_q, adc_ch_d;
    logic            round_stb_q, round_stb_d;
    logic            timeout_err_q, timeout_err_d;
    logic [10:0]     p1_y_q, p1_y_d;
    logic [10:0]     p2_y_q, p2_y_d;

    logic            tick;
    logic            in_conv;
    logic            accept;
    logic            timeout;
    logic [18:0]     prod;
    logic [10:0]     scaled;

    // 8x11 product, keep the integer part of sample*span/256, then offset into the playfield.
    assign prod   = {11'd0, adc.adc_data} * SPAN_W;
    assign scaled = Y_MIN_W + 11'(prod >> 8);

    assign tick    = enable_i && (div_cnt_q == DIV_LAST);
    assign in_conv = (state_q == S_CONV0) || (state_q == S_CONV1);
    assign accept  = in_conv && adc.adc_done;
    // A done arriving in the last allowed cycle beats the timeout.
    assign timeout = in_conv && !adc.adc_done && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        wait_cnt_d    = '0;
        p1_y_d        = p1_y_q;
        p2_y_d        = p2_y_q;
        timeout_err_d = timeout_err_q;

        if (!enable_i)                  div_cnt_d = '0;
        else if (div_cnt_q == DIV_LAST) div_cnt_d = '0;
        else                            div_cnt_d = div_cnt_q + DW'(1);

        case (state_q)
            S_IDLE:  if (tick)              state_d = S_CONV0;
            S_CONV0: if (accept || timeout) state_d = S_GAP;
            S_GAP:                          state_d = S_CONV1;
            S_CONV1: if (accept || timeout) state_d = S_DONE;
            S_DONE:                         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase

        if (in_conv && (state_d == state_q)) wait_cnt_d = wait_cnt_q + TW'(1);

        if (accept && (state_q == S_CONV0)) p1_y_d = scaled;
        if (accept && (state_q == S_CONV1)) p2_y_d = scaled;

        if (clr_err_i) timeout_err_d = 1'b0;
        if (timeout)   timeout_err_d = 1'b1;

        // Outputs are registered from the next state so they line up with the state they belong to.
        adc_req_d   = (state_d == S_CONV0) || (state_d == S_CONV1);
        adc_ch_d    = (state_d == S_CONV1);
        round_stb_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            adc_req_q     <= 1'b0;
            adc_ch_q      <= 1'b0;
            round_stb_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            p1_y_q        <= POS_RST;
            p2_y_q        <= POS_RST;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            adc_req_q     <= adc_req_d;
            adc_ch_q      <= adc_ch_d;
            round_stb_q   <= round_stb_d;
            timeout_err_q <= timeout_err_d;
            p1_y_q        <= p1_y_d;
            p2_y_q        <= p2_y_d;
        end
    end

    assign adc.adc_req   = adc_req_q;
    assign adc.adc_ch    = adc_ch_q;
    assign p1_y_o        = p1_y_q;
    assign p2_y_o        = p2_y_q;
    assign round_stb_o   = round_stb_q;
    assign timeout_err_o = timeout_err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_paddle_adc_arbiter.sv
// Bench for paddle_adc_arbiter: scenario tasks drive an ADC responder and compare against
// a paddle-position model computed directly from the scaling rule.
module tb_paddle_adc_arbiter;
    localparam int SAMPLE_DIV   = 100;
    localparam int TIMEOUT      = 20;
    localparam int LONG_TIMEOUT = 256;
    localparam int Y_MIN        = 30;
    localparam int Y_SPAN       = 420;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clr_err = 1'b0;
    always #5 clk = ~clk;

    paddle_adc_arbiter_if adc();
    paddle_adc_arbiter_if adc_l();

    logic [10:0] p1_y, p2_y, p1_y_l, p2_y_l;
    logic        round_stb, timeout_err, round_stb_l, timeout_err_l;
    logic [2:0]  state, state_l;

    paddle_adc_arbiter #(.SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT), .Y_MIN(Y_MIN), .Y_SPAN(Y_SPAN)) u_dut (
        .clk(clk), .rst(rst), .enable_i(enable), .clr_err_i(clr_err), .adc(adc),
        .p1_y_o(p1_y), .p2_y_o(p2_y), .round_stb_o(round_stb), .timeout_err_o(timeout_err),
        .state_o(state)
    );

    // Second instance with a long timeout so a conversion can outlast a whole tick period.
    paddle_adc_arbiter #(.SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(LONG_TIMEOUT), .Y_MIN(Y_MIN), .Y_SPAN(Y_SPAN)) u_dut_long (
        .clk(clk), .rst(rst), .enable_i(enable), .clr_err_i(clr_err), .adc(adc_l),
        .p1_y_o(p1_y_l), .p2_y_o(p2_y_l), .round_stb_o(round_stb_l), .timeout_err_o(timeout_err_l),
        .state_o(state_l)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [21:0] exp_q[$];

    function automatic logic [10:0] model_y(input int s);
        return 11'(Y_MIN + (s * Y_SPAN) / 256);
    endfunction

    // ---------------- clock/reset and driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1;
        enable = en;
        clr_err = 1'b0;
        adc.adc_done = 1'b0;
        adc.adc_data = 8'h00;
        adc_l.adc_done = 1'b0;
        adc_l.adc_data = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(output int wc);
        wc = 0;
        while (!adc.adc_req && wc < 3 * SAMPLE_DIV) begin
            step();
            wc++;
        end
        if (!adc.adc_req) wc = -1;
    endtask

    // Entered with adc_req high; answers in request cycle 'lat' (never if lat exceeds the wait).
    task automatic serve(input int lat, input logic [7:0] d, input logic want_ch,
                         output int hi, output logic ch_ok);
        hi = 0;
        ch_ok = 1'b1;
        while (adc.adc_req && hi < 400) begin
            hi++;
            if (adc.adc_ch !== want_ch) ch_ok = 1'b0;
            if (hi == lat) begin
                adc.adc_done = 1'b1;
                adc.adc_data = d;
            end
            step();
            adc.adc_done = 1'b0;
            adc.adc_data = 8'($urandom);
        end
    endtask

    task automatic run_round(input int lat0, input logic [7:0] d0, input int lat1, input logic [7:0] d1,
                             output int wc, output int hi0, output int gap, output int hi1,
                             output int stb, output logic [10:0] p1_mid, output logic err_mid,
                             output logic ch_ok);
        logic ok0, ok1;
        gap = 0; hi0 = 0; hi1 = 0; stb = 0; p1_mid = '0; err_mid = 1'b0; ch_ok = 1'b0;
        wait_req(wc);
        if (wc < 0) return;
        serve(lat0, d0, 1'b0, hi0, ok0);
        p1_mid = p1_y;
        err_mid = timeout_err;
        while (!adc.adc_req && gap < 10) begin
            gap++;
            stb += int'(round_stb);
            step();
        end
        serve(lat1, d1, 1'b1, hi1, ok1);
        for (int i = 0; i < 3; i++) begin
            stb += int'(round_stb);
            step();
        end
        ch_ok = ok0 && ok1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset(1'b0);
        n_tests++; if (adc.adc_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", adc.adc_req); end
        n_tests++; if (adc.adc_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", adc.adc_ch); end
        n_tests++; if (p1_y !== 11'd240) begin n_fail++; $display("FAIL reset_p1: got %0d want 240", p1_y); end
        n_tests++; if (p2_y !== 11'd240) begin n_fail++; $display("FAIL reset_p2: got %0d want 240", p2_y); end
        n_tests++; if (round_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", round_stb); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    endtask

    task automatic test_normal_round();
        int wc, hi0, gap, hi1, stb;
        logic [10:0] p1m;
        logic errm, chok;
        do_reset(1'b1);
        run_round(3, 8'h00, 3, 8'hFF, wc, hi0, gap, hi1, stb, p1m, errm, chok);
        n_tests++; if (wc !== SAMPLE_DIV) begin n_fail++; $display("FAIL normal_first_req: got cycle %0d want %0d", wc, SAMPLE_DIV); end
        n_tests++; if (hi0 !== 3) begin n_fail++; $display("FAIL normal_hi0: got %0d want 3", hi0); end
        n_tests++; if (p1m !== model_y(0)) begin n_fail++; $display("FAIL normal_p1: got %0d want %0d", p1m, model_y(0)); end
        n_tests++; if (gap !== 1) begin n_fail++; $display("FAIL normal_gap: got %0d want 1", gap); end
        n_tests++; if (p2_y !== model_y(255)) begin n_fail++; $display("FAIL normal_p2: got %0d want %0d", p2_y, model_y(255)); end
        n_tests++; if (stb !== 1) begin n_fail++; $display("FAIL normal_stb: got %0d pulses want 1", stb); end
        n_tests++; if (chok !== 1'b1) begin n_fail++; $display("FAIL normal_ch: got %b want 1", chok); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL normal_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout_ch0();
        int wc, hi0, gap, hi1, stb;
        logic [10:0] p1m;
        logic errm, chok;
        do_reset(1'b1);
        run_round(1000, 8'h11, 2, 8'h80, wc, hi0, gap, hi1, stb, p1m, errm, chok);
        n_tests++; if (hi0 !== TIMEOUT) begin n_fail++; $display("FAIL timeout_hi0: got %0d want %0d", hi0, TIMEOUT); end
        n_tests++; if (p1m !== 11'd240) begin n_fail++; $display("FAIL timeout_p1: got %0d want 240", p1m); end
        n_tests++; if (errm !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", errm); end
        n_tests++; if (p2_y !== model_y(128)) begin n_fail++; $display("FAIL timeout_p2: got %0d want %0d", p2_y, model_y(128)); end
        n_tests++; if (stb !== 1) begin n_fail++; $display("FAIL timeout_stb: got %0d pulses want 1", stb); end
    endtask

    task automatic test_done_at_timeout();
        int wc, hi0, gap, hi1, stb;
        logic [10:0] p1m;
        logic errm, chok;
        do_reset(1'b1);
        run_round(TIMEOUT, 8'h40, 4, 8'($urandom), wc, hi0, gap, hi1, stb, p1m, errm, chok);
        n_tests++; if (p1m !== model_y(64)) begin n_fail++; $display("FAIL race_p1: got %0d want %0d", p1m, model_y(64)); end
        n_tests++; if (errm !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b want 0", errm); end
        n_tests++; if (hi0 !== TIMEOUT) begin n_fail++; $display("FAIL race_hi0: got %0d want %0d", hi0, TIMEOUT); end
    endtask

    task automatic test_dropped_tick();
        int lat0, lat1, req_cnt, stb_tot, e, next_start;
        logic [7:0] d0, d1;
        logic prev;
        int rises[$];
        lat0 = $urandom_range(110, 190);
        lat1 = $urandom_range(1, 5);
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        req_cnt = 0; stb_tot = 0; prev = 1'b0;
        do_reset(1'b1);
        for (int i = 0; i < 400; i++) begin
            if (adc_l.adc_req && !prev) begin
                rises.push_back(i);
                req_cnt = 0;
            end
            if (adc_l.adc_req) req_cnt++;
            stb_tot += int'(round_stb_l);
            if (adc_l.adc_req && req_cnt == (adc_l.adc_ch ? lat1 : lat0)) begin
                adc_l.adc_done = 1'b1;
                adc_l.adc_data = adc_l.adc_ch ? d1 : d0;
            end
            prev = adc_l.adc_req;
            step();
            adc_l.adc_done = 1'b0;
        end
        // First IDLE cycle after the round; the next round needs a tick seen from IDLE.
        e = SAMPLE_DIV + lat0 + lat1 + 2;
        next_start = ((e + 1 + SAMPLE_DIV - 1) / SAMPLE_DIV) * SAMPLE_DIV;
        n_tests++; if (rises.size() !== 3) begin n_fail++; $display("FAIL drop_rises: got %0d want 3", rises.size()); end
        if (rises.size() == 3) begin
            n_tests++; if (rises[0] !== SAMPLE_DIV) begin n_fail++; $display("FAIL drop_first: got %0d want %0d", rises[0], SAMPLE_DIV); end
            n_tests++; if (rises[1] !== SAMPLE_DIV + lat0 + 1) begin n_fail++; $display("FAIL drop_ch1: got %0d want %0d", rises[1], SAMPLE_DIV + lat0 + 1); end
            n_tests++; if (rises[2] !== next_start) begin n_fail++; $display("FAIL drop_next: got %0d want %0d", rises[2], next_start); end
        end
        n_tests++; if (stb_tot !== 1) begin n_fail++; $display("FAIL drop_stb: got %0d want 1", stb_tot); end
        n_tests++; if (p1_y_l !== model_y(int'(d0))) begin n_fail++; $display("FAIL drop_p1: got %0d want %0d", p1_y_l, model_y(int'(d0))); end
        n_tests++; if (p2_y_l !== model_y(int'(d1))) begin n_fail++; $display("FAIL drop_p2: got %0d want %0d", p2_y_l, model_y(int'(d1))); end
    endtask

    task automatic test_enable_drop();
        int wc, hi, gap, req_hi;
        logic ok;
        logic [7:0] d0, d1;
        logic [10:0] p1_exp, p2_exp;
        d0 = 8'($urandom); d1 = 8'($urandom);
        do_reset(1'b1);
        wait_req(wc);
        enable = 1'b0;
        if (wc >= 0) begin
            serve(3, d0, 1'b0, hi, ok);
            gap = 0;
            while (!adc.adc_req && gap < 10) begin gap++; step(); end
            serve(2, d1, 1'b1, hi, ok);
        end
        p1_exp = model_y(int'(d0));
        p2_exp = model_y(int'(d1));
        n_tests++; if (p1_y !== p1_exp) begin n_fail++; $display("FAIL endrop_p1: got %0d want %0d", p1_y, p1_exp); end
        n_tests++; if (p2_y !== p2_exp) begin n_fail++; $display("FAIL endrop_p2: got %0d want %0d", p2_y, p2_exp); end
        req_hi = 0;
        for (int i = 0; i < 250; i++) begin
            if (adc.adc_req) req_hi++;
            if (i == 50) begin adc.adc_done = 1'b1; adc.adc_data = ~d0; end
            step();
            adc.adc_done = 1'b0;
        end
        n_tests++; if (req_hi !== 0) begin n_fail++; $display("FAIL endrop_quiet: got %0d req cycles want 0", req_hi); end
        n_tests++; if (p1_y !== p1_exp) begin n_fail++; $display("FAIL stray_p1: got %0d want %0d", p1_y, p1_exp); end
        n_tests++; if (p2_y !== p2_exp) begin n_fail++; $display("FAIL stray_p2: got %0d want %0d", p2_y, p2_exp); end
        enable = 1'b1;
        wait_req(wc);
        n_tests++; if (wc !== SAMPLE_DIV) begin n_fail++; $display("FAIL reenable_req: got %0d want %0d", wc, SAMPLE_DIV); end
    endtask

    task automatic test_reset_conv1();
        int wc, hi, gap;
        logic ok;
        do_reset(1'b1);
        wait_req(wc);
        if (wc >= 0) begin
            serve(2, 8'h10, 1'b0, hi, ok);
            gap = 0;
            while (!adc.adc_req && gap < 10) begin gap++; step(); end
        end
        n_tests++; if (p1_y !== model_y(16)) begin n_fail++; $display("FAIL rstc1_pre_p1: got %0d want %0d", p1_y, model_y(16)); end
        step();
        step();
        n_tests++; if (adc.adc_req !== 1'b1) begin n_fail++; $display("FAIL rstc1_in_conv1: got %b want 1", adc.adc_req); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (adc.adc_req !== 1'b0) begin n_fail++; $display("FAIL rstc1_req: got %b want 0", adc.adc_req); end
        n_tests++; if (p1_y !== 11'd240) begin n_fail++; $display("FAIL rstc1_p1: got %0d want 240", p1_y); end
        n_tests++; if (p2_y !== 11'd240) begin n_fail++; $display("FAIL rstc1_p2: got %0d want 240", p2_y); end
        n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rstc1_state: got %0d want %0d", state, ST_IDLE); end
        step();
        rst = 1'b0;
        adc.adc_done = 1'b1;
        adc.adc_data = 8'hFF;
        step();
        adc.adc_done = 1'b0;
        n_tests++; if (p2_y !== 11'd240) begin n_fail++; $display("FAIL late_done_p2: got %0d want 240", p2_y); end
        n_tests++; if (adc.adc_req !== 1'b0) begin n_fail++; $display("FAIL late_done_req: got %b want 0", adc.adc_req); end
    endtask

    task automatic test_err_race();
        int wc, hi;
        logic ok;
        do_reset(1'b1);
        wait_req(wc);
        repeat (TIMEOUT - 1) step();
        n_tests++; if (adc.adc_req !== 1'b1) begin n_fail++; $display("FAIL errrace_last_cycle_req: got %b want 1", adc.adc_req); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL errrace_set_wins: got %b want 1", timeout_err); end
        n_tests++; if (adc.adc_req !== 1'b0) begin n_fail++; $display("FAIL errrace_req_drop: got %b want 0", adc.adc_req); end
        step();
        serve(1, 8'h80, 1'b1, hi, ok);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL errclr: got %b want 0", timeout_err); end
    endtask

    task automatic test_random_rounds();
        int wc, hi0, gap, hi1, stb, lat0, lat1;
        logic [7:0] d0, d1;
        logic [10:0] p1m, ep1, ep2;
        logic errm, chok, eerr;
        logic [21:0] exp_v;
        ep1 = 11'd240; ep2 = 11'd240; eerr = 1'b0;
        do_reset(1'b1);
        for (int r = 0; r < 8; r++) begin
            lat0 = $urandom_range(1, TIMEOUT + 4);
            lat1 = $urandom_range(1, TIMEOUT + 4);
            d0 = 8'($urandom); d1 = 8'($urandom);
            if (lat0 <= TIMEOUT) ep1 = model_y(int'(d0)); else eerr = 1'b1;
            if (lat1 <= TIMEOUT) ep2 = model_y(int'(d1)); else eerr = 1'b1;
            exp_q.push_back({ep1, ep2});
            run_round(lat0, d0, lat1, d1, wc, hi0, gap, hi1, stb, p1m, errm, chok);
            exp_v = exp_q.pop_front();
            n_tests++; if (p1_y !== exp_v[21:11]) begin n_fail++; $display("FAIL rand_p1 r%0d: got %0d want %0d", r, p1_y, exp_v[21:11]); end
            n_tests++; if (p2_y !== exp_v[10:0]) begin n_fail++; $display("FAIL rand_p2 r%0d: got %0d want %0d", r, p2_y, exp_v[10:0]); end
            n_tests++; if (timeout_err !== eerr) begin n_fail++; $display("FAIL rand_err r%0d: got %b want %b", r, timeout_err, eerr); end
            n_tests++; if (hi0 !== ((lat0 < TIMEOUT) ? lat0 : TIMEOUT)) begin n_fail++; $display("FAIL rand_hi0 r%0d: got %0d lat %0d", r, hi0, lat0); end
            n_tests++; if (stb !== 1 || gap !== 1 || chok !== 1'b1) begin n_fail++; $display("FAIL rand_shape r%0d: stb %0d gap %0d ch_ok %b want 1 1 1", r, stb, gap, chok); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal_round();
        test_timeout_ch0();
        test_done_at_timeout();
        test_dropped_tick();
        test_enable_drop();
        test_reset_conv1();
        test_err_race();
        test_random_rounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/paddle_adc_arbiter.md
# paddle_adc_arbiter

Shares a single external 8-bit ADC between the two paddle potentiometers. On a programmable sample tick it converts channel 0 (player 1) and then channel 1 (player 2) using a request/done handshake. Each sample is scaled to the playfield vertical range, and the results are held as registered paddle positions. These registered positions drive the game controller's `p1_in` and `p2_in`.

## Interface
- `SAMPLE_DIV`, default 50000: clk cycles between sample-round starts; legal range ≥ 8.
- `TIMEOUT`, default 1024: maximum cycles `adc_req` may stay high without `adc_done`.
- `Y_MIN`, default 30: paddle y for sample 0.
- `Y_SPAN`, default 420: scale span; y = `Y_MIN` + ((sample × `Y_SPAN`) >> 8).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: allow new sample rounds.
- `adc_req`, out, 1: conversion request, level.
- `adc_ch`, out, 1: channel select; 0 = player 1, 1 = player 2; stable while `adc_req` is high.
- `adc_done`, in, 1: conversion complete, single-cycle pulse.
- `adc_data`, in, 8: sample value, valid only in the cycle where `adc_done` = 1.
- `p1_y`, out, 11: scaled player 1 position.
- `p2_y`, out, 11: scaled player 2 position.
- `round_stb`, out, 1: one-cycle pulse when a round ends, whether it completed or timed out.
- `timeout_err`, out, 1: sticky error flag.
- `clr_err`, in, 1: synchronous clear for `timeout_err`.

## Operation
- **Tick counter** `div_cnt`:
  - Counts 0 to `SAMPLE_DIV`−1 and wraps; tick is asserted when `div_cnt` = `SAMPLE_DIV`−1.
  - Held at 0 while `enable` = 0.
  - A tick arriving while the FSM is not in IDLE is dropped; there is no queueing.
- **FSM states:** IDLE, CONV0, GAP, CONV1, DONE.
  - IDLE → CONV0 on tick with `enable` = 1.
  - CONV0: `adc_req` = 1, `adc_ch` = 0. On `adc_done`, capture and scale into `p1_y`, then → GAP.
  - GAP: `adc_req` = 0 for exactly one cycle, then → CONV1.
  - CONV1: `adc_req` = 1, `adc_ch` = 1. On `adc_done`, update `p2_y`, then → DONE.
  - DONE: `round_stb` = 1 for one cycle, then → IDLE.
- **Timeout:**
  - A wait counter clears on entry to CONV0 or CONV1 and increments each cycle in those states.
  - When it reaches `TIMEOUT`−1 with no `adc_done`:
    - the position for that channel keeps its old value;
    - `timeout_err` ← 1;
    - the FSM advances exactly as if done had arrived (CONV0 → GAP, CONV1 → DONE).
  - If `adc_done` and the timeout occur in the same cycle, `adc_done` wins: the data is used and no error is raised.
- **Ignored handshake events:**
  - `adc_done` in IDLE, GAP or DONE is ignored; no output changes.
- **Error flag:**
  - `clr_err` and a new timeout in the same cycle leave `timeout_err` = 1; set wins.
- **Enable deasserted mid-round:** the round runs to completion, including GAP and CONV1. No new round starts until `enable` = 1 and the next tick.
- **Arithmetic:**
  - Product is 19 bits (8 × 11), shifted right by 8, then `Y_MIN` added in 11 bits.
  - With defaults: sample 0 → 30, sample 128 → 240, sample 255 → 448.
  - No saturation is needed for parameters satisfying `Y_MIN` + `Y_SPAN` < 2048.

## Timing
- **Reset values:**
  - `p1_y` = `p2_y` = 240;
  - `adc_req` = 0, `adc_ch` = 0, `round_stb` = 0, `timeout_err` = 0;
  - FSM = IDLE, `div_cnt` = 0.
- **All outputs are registered.**
- **Request timing:**
  - `adc_req` rises on the clock edge that registers the tick; it is visible the cycle after `div_cnt` = `SAMPLE_DIV`−1.
  - `adc_req` falls on the edge that samples `adc_done` = 1.
- **Position update latency:** `p1_y`/`p2_y` update on the same edge that samples `adc_done` = 1, i.e. one-cycle latency from the done pulse.
- **Minimum round length:** 1 + 1 + 1 + 1 + 1 cycles when done returns in the first request cycle.
- **Reset mid-conversion:**
  - `adc_req` drops asynchronously.
  - Positions return to 240.
  - A late `adc_done` after reset is ignored because the FSM is in IDLE.

## Test plan
Bench parameters: `SAMPLE_DIV` = 100, `TIMEOUT` = 20.

1. **Normal round:**
   - Stimulus: release reset with `enable` = 1; the ADC model returns done after 3 cycles with ch0 = 0x00 and ch1 = 0xFF.
   - Required: `adc_req` first rises at cycle 100; `p1_y` = 30; `p2_y` = 448; `adc_req` low for exactly one GAP cycle between channels; one `round_stb` pulse.
2. **Timeout on ch0:**
   - Stimulus: ch0 never returns done; ch1 returns 0x80.
   - Required: `adc_req` drops after 20 cycles; `p1_y` stays 240; `timeout_err` = 1; `p2_y` = 240 (from 0x80); `round_stb` pulses.
3. **Done and timeout in the same cycle:**
   - Stimulus: done with 0x40 arrives in the 20th CONV0 cycle.
   - Required: `p1_y` = 135; `timeout_err` stays 0.
4. **Dropped tick:**
   - Stimulus: ADC latency of 150 cycles on ch0.
   - Required: the tick during CONV0 is ignored; the next round starts at the first tick after IDLE; exactly one round per `round_stb`.
5. **Enable drop and stray done:**
   - Stimulus: deassert `enable` during CONV0; pulse `adc_done` in IDLE.
   - Required: the round completes through CONV1; no further `adc_req` until re-enabled; the stray done leaves positions unchanged.
6. **Async reset during CONV1, and error-flag race:**
   - Stimulus: assert async `rst` during CONV1; separately, assert `clr_err` in the same cycle as a new timeout.
   - Required: after reset, `adc_req` = 0 immediately, positions = 240, FSM = IDLE. For the race, `timeout_err` remains 1.
